// File: rtl/rx_frame_parser_module_pkg.sv
// Shared constants for the received-frame parser: header bytes, FSM state
// encodings and error codes reported on Err_Code.
package rx_frame_parser_module_pkg;

   localparam logic [7:0] HDR0_BYTE = 8'hAA;
   localparam logic [7:0] HDR1_BYTE = 8'h55;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_HDR1 = 3'd1;
   localparam logic [2:0] S_CMD  = 3'd2;
   localparam logic [2:0] S_LEN  = 3'd3;
   localparam logic [2:0] S_PAY  = 3'd4;
   localparam logic [2:0] S_CHK  = 3'd5;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_LEN  = 2'd1;
   localparam logic [1:0] ERR_CHK  = 2'd2;
   localparam logic [1:0] ERR_TO   = 2'd3;

endpackage

// File: rtl/rx_frame_parser_module_timeout.sv
// Inter-byte idle counter: clears on request, counts while enabled and
// raises a one-cycle expire pulse on the cycle it reaches TIMEOUT_CYC.
module rx_timeout_module #(
   parameter int unsigned TIMEOUT_CYC = 50000,
   parameter int unsigned TO_W        = 16
) (
   input  logic CLK,
   input  logic RSTn,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam logic [TO_W-1:0] LAST_CNT = TO_W'(TIMEOUT_CYC - 1);

   logic [TO_W-1:0] cnt_q, cnt_d;

   // A clear in the same cycle suppresses expiry, so an arriving byte always wins.
   assign expire_o = en_i && !clr_i && (cnt_q == LAST_CNT);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || expire_o) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/rx_frame_parser_module.sv
// Parses HDR0 HDR1 CMD LEN payload CHK frames from the UART receive stage,
// streaming payload bytes and flagging good or aborted frames.
module rx_frame_parser_module
   import rx_frame_parser_module_pkg::*;
#(
   parameter logic [7:0]  HDR0        = HDR0_BYTE,
   parameter logic [7:0]  HDR1        = HDR1_BYTE,
   parameter int unsigned MAX_LEN     = 64,
   parameter int unsigned TIMEOUT_CYC = 50000,
   parameter int unsigned TO_W        = 16
) (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic       RX_Done_Sig,
   input  logic [7:0] RX_Data,
   output logic [7:0] Cmd,
   output logic [7:0] Len,
   output logic [7:0] Payload_Data,
   output logic       Payload_Valid,
   output logic [7:0] Payload_Idx,
   output logic       Frame_Done_Sig,
   output logic       Frame_Err_Sig,
   output logic [1:0] Err_Code,
   output logic       Busy
);

   localparam logic [7:0] MAX_LEN_B = MAX_LEN[7:0];

   logic [2:0] state_q, state_d;
   logic [7:0] sum_q, sum_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] idx_q, idx_d;
   logic [7:0] cmd_q, cmd_d;
   logic [7:0] len_q, len_d;
   logic [7:0] pdata_q, pdata_d;
   logic [7:0] pidx_q, pidx_d;
   logic       pvld_q, pvld_d;
   logic       done_q, done_d;
   logic       ferr_q, ferr_d;
   logic [1:0] errc_q, errc_d;
   logic       expire;

   rx_timeout_module #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .TO_W        (TO_W)
   ) u_timeout (
      .CLK      (CLK),
      .RSTn     (RSTn),
      .clr_i    (RX_Done_Sig || (state_q == S_IDLE)),
      .en_i     (state_q != S_IDLE),
      .expire_o (expire)
   );

   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      cmd_d   = cmd_q;
      len_d   = len_q;
      pdata_d = pdata_q;
      pidx_d  = pidx_q;
      pvld_d  = 1'b0;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
      errc_d  = errc_q;
      if (expire) begin
         ferr_d  = 1'b1;
         errc_d  = ERR_TO;
         state_d = S_IDLE;
      end else if (RX_Done_Sig) begin
         case (state_q)
            S_IDLE: if (RX_Data == HDR0) state_d = S_HDR1;
            // A repeated HDR0 is treated as the start of a fresh frame.
            S_HDR1: begin
               if (RX_Data == HDR1)      state_d = S_CMD;
               else if (RX_Data != HDR0) state_d = S_IDLE;
            end
            S_CMD: begin
               cmd_d   = RX_Data;
               sum_d   = RX_Data;
               state_d = S_LEN;
            end
            S_LEN: begin
               len_d = RX_Data;
               sum_d = sum_q + RX_Data;
               if (RX_Data == 8'd0) begin
                  state_d = S_CHK;
               end else if (RX_Data > MAX_LEN_B) begin
                  ferr_d  = 1'b1;
                  errc_d  = ERR_LEN;
                  state_d = S_IDLE;
               end else begin
                  cnt_d   = RX_Data;
                  idx_d   = 8'd0;
                  state_d = S_PAY;
               end
            end
            S_PAY: begin
               pdata_d = RX_Data;
               pidx_d  = idx_q;
               pvld_d  = 1'b1;
               sum_d   = sum_q + RX_Data;
               idx_d   = idx_q + 8'd1;
               cnt_d   = cnt_q - 8'd1;
               if (cnt_q == 8'd1) state_d = S_CHK;
            end
            S_CHK: begin
               if (RX_Data == sum_q) begin
                  done_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
                  errc_d = ERR_CHK;
               end
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= S_IDLE;
         sum_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         cmd_q   <= '0;
         len_q   <= '0;
         pdata_q <= '0;
         pidx_q  <= '0;
         pvld_q  <= 1'b0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
         errc_q  <= ERR_NONE;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         cmd_q   <= cmd_d;
         len_q   <= len_d;
         pdata_q <= pdata_d;
         pidx_q  <= pidx_d;
         pvld_q  <= pvld_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
         errc_q  <= errc_d;
      end
   end

   assign Cmd            = cmd_q;
   assign Len            = len_q;
   assign Payload_Data   = pdata_q;
   assign Payload_Idx    = pidx_q;
   assign Payload_Valid  = pvld_q;
   assign Frame_Done_Sig = done_q;
   assign Frame_Err_Sig  = ferr_q;
   assign Err_Code       = errc_q;
   assign Busy           = (state_q != S_IDLE);

endmodule
